// File: rtl/knn_topk_if.sv
// knn_topk_if: sample stream, read port and status bundle for knn_topk_sorter.
// master = distance stage / KNN core side, slave = the sorter.
interface knn_topk_if #(
  parameter int K      = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic                   clr;
  logic                   valid_in;
  logic [DATA_W-1:0]      dist_in;
  logic [IDX_W-1:0]       idx_in;
  logic [$clog2(K)-1:0]   rd_addr;
  logic [DATA_W-1:0]      rd_dist;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_valid;
  logic [$clog2(K+1)-1:0] count;
  logic                   full;
  logic [DATA_W-1:0]      max_dist;

  modport master (
    output clr, valid_in, dist_in, idx_in, rd_addr,
    input  rd_dist, rd_idx, rd_valid, count, full, max_dist
  );

  modport slave (
    input  clr, valid_in, dist_in, idx_in, rd_addr,
    output rd_dist, rd_idx, rd_valid, count, full, max_dist
  );
endinterface

// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter: keeps the K smallest (dist, idx) samples since the last
// clear, sorted ascending, with one insert per cycle through a parallel
// compare-and-shift network. Ties keep the older entry ahead of the new one.
// Optional macro KNN_TOPK_REG_OUT_EN registers the read port (one cycle of
// read latency); without it the read port is combinational.
module knn_topk_sorter #(
  parameter int K      = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  knn_topk_if.slave   bus
);
  localparam int AW = $clog2(K);
  localparam int CW = $clog2(K+1);
  localparam logic [CW-1:0] K_CNT = CW'(K);

  logic [DATA_W-1:0] dist_q [K];
  logic [DATA_W-1:0] dist_d [K];
  logic [IDX_W-1:0]  idx_q  [K];
  logic [IDX_W-1:0]  idx_d  [K];
  logic [K-1:0]      occ_q, occ_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] max_dist_q, max_dist_d;
  // keep[i]: slot i holds an entry that stays at or ahead of the new sample.
  // Because occupied slots are a sorted prefix, keep is a thermometer code.
  logic [K-1:0]      keep;

  logic [DATA_W-1:0] rd_dist_d;
  logic [IDX_W-1:0]  rd_idx_d;
  logic              rd_valid_d;

  // Next table state: clear, clear-with-sample, or stable sorted insert.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      keep[i] = occ_q[i] && (dist_q[i] <= bus.dist_in);
    end
    dist_d  = dist_q;
    idx_d   = idx_q;
    occ_d   = occ_q;
    count_d = count_q;
    if (bus.clr) begin
      for (int i = 0; i < K; i++) begin
        dist_d[i] = '1;
        idx_d[i]  = '0;
        occ_d[i]  = 1'b0;
      end
      count_d = '0;
      if (bus.valid_in) begin
        dist_d[0] = bus.dist_in;
        idx_d[0]  = bus.idx_in;
        occ_d[0]  = 1'b1;
        count_d   = CW'(1);
      end
    end else if (bus.valid_in && !keep[K-1]) begin
      // Slot 0 can only ever take the new sample (nothing to shift in).
      if (!keep[0]) begin
        dist_d[0] = bus.dist_in;
        idx_d[0]  = bus.idx_in;
        occ_d[0]  = 1'b1;
      end
      for (int i = 1; i < K; i++) begin
        if (!keep[i]) begin
          if (keep[i-1]) begin
            dist_d[i] = bus.dist_in;
            idx_d[i]  = bus.idx_in;
            occ_d[i]  = 1'b1;
          end else begin
            dist_d[i] = dist_q[i-1];
            idx_d[i]  = idx_q[i-1];
            occ_d[i]  = occ_q[i-1];
          end
        end
      end
      count_d = (count_q == K_CNT) ? count_q : count_q + 1'b1;
    end
    full_d     = (count_d == K_CNT);
    max_dist_d = full_d ? dist_d[K-1] : '1;
  end

  // Table and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '1;
        idx_q[i]  <= '0;
      end
      occ_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      max_dist_q <= '1;
    end else begin
      dist_q     <= dist_d;
      idx_q      <= idx_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      full_q     <= full_d;
      max_dist_q <= max_dist_d;
    end
  end

  // Read mux; out-of-range or empty slots read as zero.
  always_comb begin
    rd_dist_d  = '0;
    rd_idx_d   = '0;
    rd_valid_d = 1'b0;
    for (int i = 0; i < K; i++) begin
      if ((bus.rd_addr == AW'(i)) && occ_q[i]) begin
        rd_dist_d  = dist_q[i];
        rd_idx_d   = idx_q[i];
        rd_valid_d = 1'b1;
      end
    end
  end

`ifdef KNN_TOPK_REG_OUT_EN
  logic [DATA_W-1:0] rd_dist_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              rd_valid_q;

  // Registered read port, cleared along with the table.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      rd_dist_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_dist_q  <= rd_dist_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_dist  = rd_dist_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.rd_valid = rd_valid_q;
`else
  assign bus.rd_dist  = rd_dist_d;
  assign bus.rd_idx   = rd_idx_d;
  assign bus.rd_valid = rd_valid_d;
`endif

  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.max_dist = max_dist_q;
endmodule
